shared_dff_arbiter: RTL

Round-robin arbiter and sequencer granting N requesters exclusive write access to one shared WIDTH-bit D-register with complementary outputs (q, q_bar). Sits between requesting agents and the shared flop bank: it arbitrates, commits one write per access, then enforces a programmable hold window before re-arbitrating. The block carries its own concurrent SVA checks on the register and grant invariants.

---
 rtl/shared_dff_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/shared_dff_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/shared_dff_pkg.sv
// ============================================================================
// Module      : shared_dff_pkg
// Description : Shared types and constants for the shared D-register arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shared_dff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Sized for the largest legal hold window (15).
    localparam int HOLD_CNT_W = $clog2(16);

    localparam logic Q_RST_BIT    = 1'b0;
    localparam logic QBAR_RST_BIT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first set request at or above
//               ptr, wrapping, as one-hot plus index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(ptr_i) + k) % N_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/shared_dff_arbiter.sv
// ============================================================================
// Module      : shared_dff_arbiter
// Description : Round-robin write sequencer for one shared WIDTH-bit register
//               with complementary outputs and a post-write hold window.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shared_dff_arbiter
    import shared_dff_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] wdata_i,
    output logic [N_REQ-1:0]       grant_o,
    output logic [WIDTH-1:0]       q_o,
    output logic [WIDTH-1:0]       q_bar_o,
    output logic                   busy_o
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       widx_q, widx_d;
    logic [HOLD_CNT_W-1:0]  hold_q, hold_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic [WIDTH-1:0]       qbar_q, qbar_d;

    logic [N_REQ-1:0]       arb_gnt;
    logic [PTR_W-1:0]       arb_idx;
    logic                   arb_valid;
    logic [WIDTH-1:0]       wdata_slice [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign wdata_slice[g] = wdata_i[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        widx_d  = widx_q;
        hold_d  = hold_q;
        grant_d = '0;
        q_d     = q_q;
        qbar_d  = qbar_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_gnt;
                    widx_d  = arb_idx;
                    ptr_d   = (arb_idx == PTR_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Commit regardless of whether the winner still requests.
                q_d    = wdata_slice[widx_q];
                qbar_d = ~wdata_slice[widx_q];
                if (HOLD_CYCLES > 0) begin
                    state_d = HOLD;
                    hold_d  = HOLD_CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            widx_q  <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            q_q     <= {WIDTH{Q_RST_BIT}};
            qbar_q  <= {WIDTH{QBAR_RST_BIT}};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            widx_q  <= widx_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            q_q     <= q_d;
            qbar_q  <= qbar_d;
        end
    end

    assign grant_o = grant_q;
    assign q_o     = q_q;
    assign q_bar_o = qbar_q;
    assign busy_o  = (state_q != IDLE);

    a_qbar_complement : assert property (@(posedge clk) disable iff (!rstn)
        q_bar_o == ~q_o);

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rstn)
        $onehot0(grant_o));

    a_grant_had_req : assert property (@(posedge clk) disable iff (!rstn)
        (grant_o & ~$past(req_i)) == '0);

    a_grant_not_back_to_back : assert property (@(posedge clk) disable iff (!rstn)
        (|grant_o) |=> (grant_o == '0));

    a_no_grant_in_hold : assert property (@(posedge clk) disable iff (!rstn)
        (state_q == HOLD) |-> (grant_o == '0));

endmodule

`default_nettype wire
